// File: rtl/alu_muldiv_seq.sv
// Iterative restoring radix-2 divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; special cases (divide-by-zero, signed overflow) complete in one cycle.
module alu_muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      divOp,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    input  logic            flush,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state_q, state_d;

    logic [1:0]      op_q;
    logic [XLEN:0]   rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic            q_neg_q;
    logic            r_neg_q;
    logic [XLEN-1:0] result_q;

    function automatic logic [XLEN-1:0] neg_if(input logic c, input logic [XLEN-1:0] v);
        logic signed [XLEN-1:0] sv;
        sv = $signed(v);
        return c ? $unsigned(-sv) : v;
    endfunction

    // Operand decode for a request arriving in IDLE
    logic            op_signed;
    logic            sign_a, sign_b;
    logic            div_zero, sgn_ovf, special;
    logic [XLEN-1:0] special_res;
    logic            accept;

    assign op_signed = ~divOp[0];
    assign sign_a    = op_signed & srcA[XLEN-1];
    assign sign_b    = op_signed & srcB[XLEN-1];
    assign div_zero  = (srcB == '0);
    assign sgn_ovf   = op_signed && (srcA == {1'b1, {(XLEN-1){1'b0}}}) && (srcB == '1);
    assign special   = div_zero | sgn_ovf;
    assign accept    = (state_q == IDLE) && start && !flush;

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = divOp[1] ? srcA : '1;
        else if (!divOp[1])
            special_res = {1'b1, {(XLEN-1){1'b0}}};
    end

    // One restoring step: shift the partial remainder left, subtract when it fits
    logic [XLEN:0]   rem_sh, rem_nx;
    logic [XLEN-1:0] quo_nx;
    logic            fits;
    logic            last_step;

    assign rem_sh    = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    assign fits      = (rem_sh >= {1'b0, dvs_q});
    assign rem_nx    = fits ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
    assign quo_nx    = {quo_q[XLEN-2:0], fits};
    assign last_step = (cnt_q == CNT_W'(XLEN - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = special ? DONE : CALC;
            CALC: begin
                if (flush)          state_d = IDLE;
                else if (last_step) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q     <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    op_q <= divOp;
                    if (special) begin
                        result_q <= special_res;
                    end else begin
                        rem_q   <= '0;
                        quo_q   <= neg_if(sign_a, srcA);
                        dvs_q   <= neg_if(sign_b, srcB);
                        cnt_q   <= '0;
                        q_neg_q <= sign_a ^ sign_b;
                        r_neg_q <= sign_a;
                    end
                end
                CALC: if (!flush) begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_step)
                        result_q <= op_q[1] ? neg_if(r_neg_q, rem_nx[XLEN-1:0])
                                            : neg_if(q_neg_q, quo_nx);
                end
                default: ;
            endcase
        end
    end

    assign ready  = (state_q == IDLE);
    assign busy   = (state_q == CALC) || (state_q == DONE);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with an expected-result queue and immediate assertions.
module tb_alu_muldiv_seq;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n, start, flush;
    logic [1:0]      divOp;
    logic [XLEN-1:0] srcA, srcB;
    logic            ready, busy, done;
    logic [XLEN-1:0] result;

    int checks = 0;
    int failures = 0;
    logic [XLEN-1:0] exp_q[$];
    logic [XLEN-1:0] prev_res;

    always #5 clk = ~clk;

    alu_muldiv_seq #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .divOp(divOp),
        .srcA(srcA), .srcB(srcB), .flush(flush),
        .ready(ready), .busy(busy), .done(done), .result(result)
    );

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
        case (op)
            2'd0:    return $signed(a) / $signed(b);
            2'd1:    return a / b;
            2'd2:    return $signed(a) % $signed(b);
            default: return a % b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input bit hold, input string tag);
        logic [31:0] e;
        int k;
        exp_q.push_back(exp);
        @(negedge clk);
        divOp = op; srcA = a; srcB = b; start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        srcA = $urandom; srcB = $urandom; divOp = 2'($urandom);
        k = 1;
        while (!done && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        e = exp_q.pop_front();
        check({tag, " done"}, {31'b0, done}, 32'd1);
        check({tag, " latency"}, k, lat);
        check({tag, " result"}, result, e);
        prev_res = e;
        @(posedge clk); #1;
        check({tag, " pulse_end"}, {30'b0, done, ready}, 32'b01);
    endtask

    initial begin
        bit seen;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; divOp = '0; srcA = '0; srcB = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ready", {31'b0, ready}, 32'd1);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        run_op(2'b01, 32'd100, 32'd7, 32'd14, 33, 1'b0, "divu_100_7");
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 33, 1'b0, "remu_100_7");
        run_op(2'b00, -32'sd7, 32'd2, 32'hFFFF_FFFD, 33, 1'b0, "div_m7_2");
        run_op(2'b10, -32'sd7, 32'd2, 32'hFFFF_FFFF, 33, 1'b0, "rem_m7_2");
        run_op(2'b10, 32'd7, -32'sd2, 32'd1, 33, 1'b0, "rem_7_m2");
        run_op(2'b00, 32'd12345, 32'd0, 32'hFFFF_FFFF, 1, 1'b0, "div_by0");
        run_op(2'b11, 32'h1234, 32'd0, 32'h1234, 1, 1'b0, "remu_by0");
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0, "div_ovf");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 1'b0, "rem_ovf");
        run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 1'b0, "divu_max");
        run_op(2'b00, 32'h8000_0000, 32'd2, 32'hC000_0000, 33, 1'b0, "div_min_2");

        // Flush ten edges after acceptance
        @(negedge clk);
        divOp = 2'b01; srcA = 32'd1000; srcB = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush ready", {31'b0, ready}, 32'd1);
        check("flush done", {31'b0, done}, 32'd0);
        check("flush result", result, prev_res);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        check("flush no_done", {31'b0, seen}, 32'd0);
        run_op(2'b01, 32'd9, 32'd3, 32'd3, 33, 1'b0, "divu_9_3");

        // Flush together with start in IDLE drops the request
        @(negedge clk);
        divOp = 2'b01; srcA = 32'd50; srcB = 32'd5; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("idle_flush ready", {31'b0, ready}, 32'd1);
        seen = 1'b0;
        repeat (36) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        check("idle_flush no_done", {31'b0, seen}, 32'd0);

        // Reset mid-calculation
        @(negedge clk);
        divOp = 2'b00; srcA = 32'd777; srcB = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        check("midreset ready", {31'b0, ready}, 32'd1);
        check("midreset busy", {31'b0, busy}, 32'd0);
        check("midreset done", {31'b0, done}, 32'd0);
        check("midreset result", result, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // start held high through the busy period is not re-accepted
        run_op(2'b11, 32'd1000, 32'd7, 32'd6, 33, 1'b1, "remu_held");

        for (int i = 0; i < 6; i++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            rb  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (i == 5) rb = -32'sd3;
            run_op(rop, ra, rb, model(rop, ra, rb), 33, 1'b0, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
